// File: rtl/nprime0_writer.sv
// nprime0_writer
// Computes the Montgomery constant n'0 = -n0^-1 mod 2^DATA_WIDTH from the low
// modulus word n0 and writes it to word 0 of the single-word nprime0 memory.
// The computation retires one result bit per cycle, so an odd n0 takes
// DATA_WIDTH+2 cycles from accept to done. An even n0 has no inverse: the
// block flags error and skips the memory write.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request pulse; n0 is captured on the accepting edge
//   n0           low modulus word
//   busy         high while a request is in flight (through the done cycle)
//   done         one-cycle completion pulse (success or error)
//   error        captured n0 was even; held until the next accepted start
//   nprime0      result register (Y)
//   mem_address  memory write address, always word 0
//   mem_data     memory write data, nonzero only in the write cycle
//   mem_wren     memory write enable, one cycle per successful computation
module nprime0_writer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] n0,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] nprime0,
   output logic                  mem_address,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_wren
);

   localparam int IW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [IW-1:0] LAST_I = IW'(DATA_WIDTH - 1);
   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   typedef enum logic [1:0] {IDLE, CALC, WRITE, FIN} state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] n_reg;   // captured modulus word N
   logic [DATA_WIDTH-1:0] a_reg;   // running low bits of N*Y
   logic [DATA_WIDTH-1:0] y_reg;   // result under construction
   logic [IW-1:0]         i_reg;   // bit being decided this cycle

   logic [DATA_WIDTH-1:0] a_nxt;
   logic [DATA_WIDTH-1:0] y_nxt;
   logic                  accept;

   // Bit i of N*Y must end up 1. If it is currently 0, setting Y[i] adds
   // N<<i to the product; since N is odd this flips bit i and never touches
   // lower bits. Carries above DATA_WIDTH are irrelevant and dropped.
   always_comb begin
      a_nxt = a_reg;
      y_nxt = y_reg;
      if (!a_reg[i_reg]) begin
         a_nxt = a_reg + (n_reg << i_reg);
         y_nxt = y_reg | (ONE << i_reg);
      end
   end

   // The done cycle's closing edge already counts as idle, so a start
   // presented there (or held high) is taken without a dead cycle.
   assign accept = start && ((state == IDLE) || (state == FIN));

   assign nprime0     = y_reg;
   assign mem_address = 1'b0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         n_reg    <= '0;
         a_reg    <= '0;
         y_reg    <= '0;
         i_reg    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         mem_data <= '0;
         mem_wren <= 1'b0;
      end else begin
         done     <= 1'b0;
         mem_wren <= 1'b0;
         mem_data <= '0;
         if (accept) begin
            busy <= 1'b1;
            if (n0[0]) begin
               n_reg <= n0;
               a_reg <= '0;
               y_reg <= '0;
               i_reg <= '0;
               error <= 1'b0;
               state <= CALC;
            end else begin
               // Even modulus: report straight away, leave memory alone.
               y_reg <= '0;
               error <= 1'b1;
               done  <= 1'b1;
               state <= FIN;
            end
         end else begin
            case (state)
               IDLE: ;
               CALC: begin
                  a_reg <= a_nxt;
                  y_reg <= y_nxt;
                  i_reg <= i_reg + 1'b1;
                  if (i_reg == LAST_I) begin
                     // Write strobe is set up here so it is a clean
                     // registered pulse during the WRITE cycle.
                     mem_wren <= 1'b1;
                     mem_data <= y_nxt;
                     state    <= WRITE;
                  end
               end
               WRITE: begin
                  done  <= 1'b1;
                  state <= FIN;
               end
               FIN: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_nprime0_writer.sv
// Directed bench for nprime0_writer: reset state, known n'0 values, even n0,
// back-to-back accepts, ignored starts while busy, mid-run reset, and a
// sweep of random odd n0 checked against n0*n'0 == -1 mod 2^32.
module tb_nprime0_writer;

   localparam int DW = 32;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] n0 = '0;
   logic          busy, done, error, mem_address, mem_wren;
   logic [DW-1:0] nprime0, mem_data;

   int n_run = 0;
   int n_fail = 0;

   nprime0_writer #(.DATA_WIDTH(DW)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .n0(n0),
      .busy(busy), .done(done), .error(error), .nprime0(nprime0),
      .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts a request at the current negedge and follows it to done.
   // Cycle c is the cycle after edge E(c-1), E0 being the accepting edge.
   // poke_cyc>0 raises start with poke_v for that one cycle mid-run.
   // Returns at the negedge inside the done cycle with start low.
   task automatic run(input logic [DW-1:0] v, input int poke_cyc, input logic [DW-1:0] poke_v,
                      output int wc, output logic [DW-1:0] wd, output int dc,
                      output logic derr, output logic [DW-1:0] np,
                      output int nwren, output int nbusy);
      int c;
      c = 0; wc = 0; wd = '0; dc = 0; derr = 1'b0; np = '0; nwren = 0; nbusy = 0;
      start = 1'b1;
      n0    = v;
      while (dc == 0 && c < 60) begin
         @(negedge clock);
         c++;
         if (mem_wren) begin
            nwren++;
            wc = c;
            wd = mem_data;
            chk("wr_addr", 64'(mem_address), 64'd0);
         end
         if (busy) nbusy++;
         if (done) begin
            dc   = c;
            derr = error;
            np   = nprime0;
         end
         start = 1'b0;
         if (c == poke_cyc) begin
            start = 1'b1;
            n0    = poke_v;
         end
      end
      start = 1'b0;
      if (dc == 0) chk("done_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      int wc, dc, nw, nb, cnt_w, cnt_b, cnt_d;
      logic [DW-1:0] wd, np, v;
      logic derr;
      logic [63:0] prod;

      // Reset state
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_wren", 64'(mem_wren), 64'd0);
      chk("rst_nprime0", 64'(nprime0), 64'd0);
      chk("rst_mdata", 64'(mem_data), 64'd0);
      chk("rst_maddr", 64'(mem_address), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // n0 = 1: full timing check
      run(32'h1, 0, '0, wc, wd, dc, derr, np, nw, nb);
      chk("n1_wren_cyc", 64'(wc), 64'd33);
      chk("n1_wdata", 64'(wd), 64'hFFFFFFFF);
      chk("n1_done_cyc", 64'(dc), 64'd34);
      chk("n1_error", 64'(derr), 64'd0);
      chk("n1_nprime0", 64'(np), 64'hFFFFFFFF);
      chk("n1_nwren", 64'(nw), 64'd1);
      chk("n1_busy_cycles", 64'(nb), 64'd34);
      @(negedge clock);
      chk("n1_busy_after", 64'(busy), 64'd0);
      chk("n1_done_after", 64'(done), 64'd0);
      chk("n1_mdata_after", 64'(mem_data), 64'd0);

      // n0 = 3 then n0 = 5 accepted on the done cycle's closing edge
      run(32'h3, 0, '0, wc, wd, dc, derr, np, nw, nb);
      chk("n3_nprime0", 64'(np), 64'h55555555);
      chk("n3_wdata", 64'(wd), 64'h55555555);
      run(32'h5, 0, '0, wc, wd, dc, derr, np, nw, nb);
      chk("n5_b2b_done_cyc", 64'(dc), 64'd34);
      chk("n5_b2b_wren_cyc", 64'(wc), 64'd33);
      chk("n5_nprime0", 64'(np), 64'h33333333);
      chk("n5_busy_cycles", 64'(nb), 64'd34);
      @(negedge clock);

      // Even n0
      run(32'h10, 0, '0, wc, wd, dc, derr, np, nw, nb);
      chk("even_done_cyc", 64'(dc), 64'd1);
      chk("even_error", 64'(derr), 64'd1);
      chk("even_nprime0", 64'(np), 64'd0);
      chk("even_nwren", 64'(nw), 64'd0);
      chk("even_busy_cycles", 64'(nb), 64'd1);
      @(negedge clock);
      chk("even_busy_after", 64'(busy), 64'd0);
      chk("even_error_held", 64'(error), 64'd1);
      chk("even_wren_after", 64'(mem_wren), 64'd0);

      // n0 = all ones; also clears the held error
      run(32'hFFFFFFFF, 0, '0, wc, wd, dc, derr, np, nw, nb);
      chk("nff_nprime0", 64'(np), 64'h1);
      chk("nff_error", 64'(derr), 64'd0);
      chk("nff_nwren", 64'(nw), 64'd1);
      @(negedge clock);

      // start with a different n0 during CALC is ignored and not queued
      run(32'h3, 5, 32'h5, wc, wd, dc, derr, np, nw, nb);
      chk("poke_nprime0", 64'(np), 64'h55555555);
      chk("poke_wdata", 64'(wd), 64'h55555555);
      chk("poke_nwren", 64'(nw), 64'd1);
      cnt_w = 0; cnt_b = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (mem_wren) cnt_w++;
         if (busy) cnt_b++;
      end
      chk("poke_no_queue_wren", 64'(cnt_w), 64'd0);
      chk("poke_no_queue_busy", 64'(cnt_b), 64'd0);

      // Reset in the middle of CALC
      start = 1'b1;
      n0    = 32'h3;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 9; k++) @(negedge clock);
      chk("mid_busy_before", 64'(busy), 64'd1);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_nprime0", 64'(nprime0), 64'd0);
      chk("mid_rst_wren", 64'(mem_wren), 64'd0);
      chk("mid_rst_error", 64'(error), 64'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      cnt_w = 0; cnt_b = 0; cnt_d = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if (mem_wren) cnt_w++;
         if (busy) cnt_b++;
         if (done) cnt_d++;
      end
      chk("mid_no_wren", 64'(cnt_w), 64'd0);
      chk("mid_no_busy", 64'(cnt_b), 64'd0);
      chk("mid_no_done", 64'(cnt_d), 64'd0);
      chk("mid_nprime0", 64'(nprime0), 64'd0);

      // Random odd n0, issued back-to-back
      for (int k = 0; k < 1000; k++) begin
         v = $urandom() | 32'h1;
         run(v, 0, '0, wc, wd, dc, derr, np, nw, nb);
         prod = 64'(v) * 64'(np);
         chk("rand_product", 64'(prod[31:0]), 64'hFFFFFFFF);
         chk("rand_wdata", 64'(wd), 64'(np));
         chk("rand_done_cyc", 64'(dc), 64'd34);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
